// File: rtl/video_timing_pkg.sv
// Shared video timing constants, sync polarity values and the control bundle
// that travels from the counters through the latency-matching delay line.
package video_timing_pkg;

    localparam int H_ACTIVE_480P = 640;
    localparam int H_FP_480P     = 16;
    localparam int H_SYNC_480P   = 96;
    localparam int H_BP_480P     = 48;
    localparam int V_ACTIVE_480P = 480;
    localparam int V_FP_480P     = 10;
    localparam int V_SYNC_480P   = 2;
    localparam int V_BP_480P     = 33;

    localparam int H_ACTIVE_720P = 1280;
    localparam int H_FP_720P     = 110;
    localparam int H_SYNC_720P   = 40;
    localparam int H_BP_720P     = 220;
    localparam int V_ACTIVE_720P = 720;
    localparam int V_FP_720P     = 5;
    localparam int V_SYNC_720P   = 5;
    localparam int V_BP_720P     = 20;

    localparam logic SYNC_ACT_LOW  = 1'b0;
    localparam logic SYNC_ACT_HIGH = 1'b1;

    // Field order fixes the bit layout used for the delay line reset value.
    typedef struct packed {
        logic active;
        logic hsync;
        logic vsync;
    } vid_ctl_t;

    function automatic int total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/sig_delay.sv
// Fixed-depth shift register with async reset to a per-bit value.
// DEPTH=0 degenerates to a plain wire.
module sig_delay #(
    parameter int               WIDTH   = 1,
    parameter int               DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    generate
        if (DEPTH == 0) begin : g_wire
            logic w_unused_clk_rst;
            assign w_unused_clk_rst = i_clk ^ i_rst;
            assign o_q = i_d;
        end else begin : g_pipe
            logic [DEPTH-1:0][WIDTH-1:0] r_pipe;
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    r_pipe <= {DEPTH{RST_VAL}};
                end else begin
                    r_pipe[0] <= i_d;
                    for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
                end
            end
            assign o_q = r_pipe[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_out.sv
// Parametrised video timing generator with a latency-matched, registered VGA
// output stage. Coordinates leave combinationally; pins trail by PIX_LATENCY+1.
module vga_timing_out
    import video_timing_pkg::*;
#(
    parameter int   H_ACTIVE    = H_ACTIVE_480P,
    parameter int   H_FP        = H_FP_480P,
    parameter int   H_SYNC      = H_SYNC_480P,
    parameter int   H_BP        = H_BP_480P,
    parameter int   V_ACTIVE    = V_ACTIVE_480P,
    parameter int   V_FP        = V_FP_480P,
    parameter int   V_SYNC      = V_SYNC_480P,
    parameter int   V_BP        = V_BP_480P,
    parameter logic HSYNC_POL   = SYNC_ACT_LOW,
    parameter logic VSYNC_POL   = SYNC_ACT_LOW,
    parameter int   COLOR_BITS  = 4,
    parameter int   COORD_W     = 10,
    parameter int   PIX_LATENCY = 1
) (
    input  logic                  i_clk_pix,
    input  logic                  i_rst_pix,
    output logic [COORD_W-1:0]    o_x,
    output logic [COORD_W-1:0]    o_y,
    output logic                  o_line_start,
    output logic                  o_frame_start,
    output logic [7:0]            o_frame_cnt,
    input  logic [COLOR_BITS-1:0] i_pix_r,
    input  logic [COLOR_BITS-1:0] i_pix_g,
    input  logic [COLOR_BITS-1:0] i_pix_b,
    output logic [COLOR_BITS-1:0] o_vga_r,
    output logic [COLOR_BITS-1:0] o_vga_g,
    output logic [COLOR_BITS-1:0] o_vga_b,
    output logic                  o_vga_hsync,
    output logic                  o_vga_vsync,
    output logic                  o_vga_de
);

    localparam int H_TOTAL = total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
    localparam logic [COORD_W-1:0] H_ACT    = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] V_ACT    = COORD_W'(V_ACTIVE);
    localparam logic [COORD_W-1:0] HS_START = COORD_W'(H_ACTIVE + H_FP);
    localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [COORD_W-1:0] VS_START = COORD_W'(V_ACTIVE + V_FP);
    localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_ACTIVE + V_FP + V_SYNC);

    localparam vid_ctl_t CTL_IDLE = '{active: 1'b0, hsync: ~HSYNC_POL, vsync: ~VSYNC_POL};

    logic [COORD_W-1:0] r_h;
    logic [COORD_W-1:0] r_v;
    logic [7:0]         r_frame_cnt;

    always_ff @(posedge i_clk_pix or posedge i_rst_pix) begin
        if (i_rst_pix) begin
            r_h         <= '0;
            r_v         <= '0;
            r_frame_cnt <= '0;
        end else if (r_h == H_LAST) begin
            r_h <= '0;
            if (r_v == V_LAST) begin
                r_v         <= '0;
                r_frame_cnt <= r_frame_cnt + 8'd1;
            end else begin
                r_v <= r_v + 1'b1;
            end
        end else begin
            r_h <= r_h + 1'b1;
        end
    end

    assign o_x           = r_h;
    assign o_y           = r_v;
    assign o_line_start  = (r_h == '0);
    assign o_frame_start = (r_h == '0) && (r_v == '0);
    assign o_frame_cnt   = r_frame_cnt;

    logic     w_hs_asserted;
    logic     w_vs_asserted;
    vid_ctl_t w_ctl;
    vid_ctl_t w_ctl_dly;

    assign w_hs_asserted = (r_h >= HS_START) && (r_h < HS_END);
    assign w_vs_asserted = (r_v >= VS_START) && (r_v < VS_END);
    assign w_ctl.active  = (r_h < H_ACT) && (r_v < V_ACT);
    assign w_ctl.hsync   = w_hs_asserted ? HSYNC_POL : ~HSYNC_POL;
    assign w_ctl.vsync   = w_vs_asserted ? VSYNC_POL : ~VSYNC_POL;

    // Aligns control with the pixel generator's output for the same coordinate.
    sig_delay #(
        .WIDTH   ($bits(vid_ctl_t)),
        .DEPTH   (PIX_LATENCY),
        .RST_VAL (CTL_IDLE)
    ) u_ctl_dly (
        .i_clk (i_clk_pix),
        .i_rst (i_rst_pix),
        .i_d   (w_ctl),
        .o_q   (w_ctl_dly)
    );

    always_ff @(posedge i_clk_pix or posedge i_rst_pix) begin
        if (i_rst_pix) begin
            o_vga_r     <= '0;
            o_vga_g     <= '0;
            o_vga_b     <= '0;
            o_vga_de    <= 1'b0;
            o_vga_hsync <= ~HSYNC_POL;
            o_vga_vsync <= ~VSYNC_POL;
        end else begin
            o_vga_de    <= w_ctl_dly.active;
            o_vga_hsync <= w_ctl_dly.hsync;
            o_vga_vsync <= w_ctl_dly.vsync;
            if (w_ctl_dly.active) begin
                o_vga_r <= i_pix_r;
                o_vga_g <= i_pix_g;
                o_vga_b <= i_pix_b;
            end else begin
                o_vga_r <= '0;
                o_vga_g <= '0;
                o_vga_b <= '0;
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_out.sv
// Three timing configurations driven from one clock/reset; every cycle each
// output is compared with a closed-form model of the raster position.
module tb_vga_timing_out;

    typedef struct {
        int ha, hfp, hs, hbp;
        int va, vfp, vs, vbp;
        int lat;
        bit hp, vp;
    } cfg_t;

    typedef struct {
        int          x, y;
        bit          ls, fs;
        int          fc;
        logic [11:0] rgb;
        bit          hs, vs, de;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int ncmp, nfail, n;
    cfg_t c_def, c_med, c_tiny;
    logic [11:0] pd_def, pd_med, pd_tiny;
    logic [11:0] pp_def, pp_med, pp_tiny;

    logic [9:0] def_x, def_y, med_x, med_y, tiny_x, tiny_y;
    logic       def_ls, def_fs, med_ls, med_fs, tiny_ls, tiny_fs;
    logic [7:0] def_fc, med_fc, tiny_fc;
    logic [3:0] def_r, def_g, def_b, med_r, med_g, med_b, tiny_r, tiny_g, tiny_b;
    logic       def_hs, def_vs, def_de, med_hs, med_vs, med_de, tiny_hs, tiny_vs, tiny_de;

    vga_timing_out u_def (
        .i_clk_pix(clk), .i_rst_pix(rst),
        .o_x(def_x), .o_y(def_y), .o_line_start(def_ls), .o_frame_start(def_fs),
        .o_frame_cnt(def_fc),
        .i_pix_r(pd_def[11:8]), .i_pix_g(pd_def[7:4]), .i_pix_b(pd_def[3:0]),
        .o_vga_r(def_r), .o_vga_g(def_g), .o_vga_b(def_b),
        .o_vga_hsync(def_hs), .o_vga_vsync(def_vs), .o_vga_de(def_de)
    );

    vga_timing_out #(
        .H_ACTIVE(40), .H_FP(4), .H_SYNC(6), .H_BP(5),
        .V_ACTIVE(20), .V_FP(2), .V_SYNC(3), .V_BP(4),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .PIX_LATENCY(3)
    ) u_med (
        .i_clk_pix(clk), .i_rst_pix(rst),
        .o_x(med_x), .o_y(med_y), .o_line_start(med_ls), .o_frame_start(med_fs),
        .o_frame_cnt(med_fc),
        .i_pix_r(pd_med[11:8]), .i_pix_g(pd_med[7:4]), .i_pix_b(pd_med[3:0]),
        .o_vga_r(med_r), .o_vga_g(med_g), .o_vga_b(med_b),
        .o_vga_hsync(med_hs), .o_vga_vsync(med_vs), .o_vga_de(med_de)
    );

    vga_timing_out #(
        .H_ACTIVE(8), .H_FP(1), .H_SYNC(1), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .PIX_LATENCY(0)
    ) u_tiny (
        .i_clk_pix(clk), .i_rst_pix(rst),
        .o_x(tiny_x), .o_y(tiny_y), .o_line_start(tiny_ls), .o_frame_start(tiny_fs),
        .o_frame_cnt(tiny_fc),
        .i_pix_r(pd_tiny[11:8]), .i_pix_g(pd_tiny[7:4]), .i_pix_b(pd_tiny[3:0]),
        .o_vga_r(tiny_r), .o_vga_g(tiny_g), .o_vga_b(tiny_b),
        .o_vga_hsync(tiny_hs), .o_vga_vsync(tiny_vs), .o_vga_de(tiny_de)
    );

    // Raster position k cycles after reset release; the pins show the raster
    // position from lat+1 cycles ago with the pixel driven one cycle ago.
    function automatic exp_t model(cfg_t c, int k, logic [11:0] ppix);
        exp_t e;
        int ht, vt, m, h, v;
        ht    = c.ha + c.hfp + c.hs + c.hbp;
        vt    = c.va + c.vfp + c.vs + c.vbp;
        e.x   = k % ht;
        e.y   = (k / ht) % vt;
        e.ls  = (e.x == 0);
        e.fs  = (e.x == 0) && (e.y == 0);
        e.fc  = (k / (ht * vt)) % 256;
        m     = k - 1 - c.lat;
        if (m < 0) begin
            e.de  = 1'b0;
            e.hs  = !c.hp;
            e.vs  = !c.vp;
            e.rgb = '0;
        end else begin
            h     = m % ht;
            v     = (m / ht) % vt;
            e.de  = (h < c.ha) && (v < c.va);
            e.hs  = (h >= c.ha + c.hfp && h < c.ha + c.hfp + c.hs) ? c.hp : !c.hp;
            e.vs  = (v >= c.va + c.vfp && v < c.va + c.vfp + c.vs) ? c.vp : !c.vp;
            e.rgb = e.de ? ppix : 12'h000;
        end
        return e;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        ncmp++;
        assert (obs === expv) else begin
            nfail++;
            $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, n, obs, expv);
        end
    endtask

    task automatic check_inst(input string nm, input cfg_t c, input int k, input logic [11:0] ppix,
                              input logic [9:0] ox, input logic [9:0] oy, input logic ols,
                              input logic ofs, input logic [7:0] ofc, input logic [11:0] orgb,
                              input logic ohs, input logic ovs, input logic ode);
        exp_t e;
        e = model(c, k, ppix);
        check({nm, ".x"},      64'(ox),  64'(e.x));
        check({nm, ".y"},      64'(oy),  64'(e.y));
        check({nm, ".starts"}, 64'({ols, ofs}), 64'({e.ls, e.fs}));
        check({nm, ".fcnt"},   64'(ofc), 64'(e.fc));
        check({nm, ".rgb"},    64'(orgb), 64'(e.rgb));
        check({nm, ".sync_de"}, 64'({ohs, ovs, ode}), 64'({e.hs, e.vs, e.de}));
    endtask

    task automatic check_all(input int k);
        check_inst("def", c_def, k, pp_def, def_x, def_y, def_ls, def_fs, def_fc,
                   {def_r, def_g, def_b}, def_hs, def_vs, def_de);
        check_inst("med", c_med, k, pp_med, med_x, med_y, med_ls, med_fs, med_fc,
                   {med_r, med_g, med_b}, med_hs, med_vs, med_de);
        check_inst("tiny", c_tiny, k, pp_tiny, tiny_x, tiny_y, tiny_ls, tiny_fs, tiny_fc,
                   {tiny_r, tiny_g, tiny_b}, tiny_hs, tiny_vs, tiny_de);
    endtask

    // Called at a falling edge: check this interval, then drive the next pixels.
    task automatic run(input int cyc, input bit hold_f);
        repeat (cyc) begin
            #1;
            check_all(n);
            pd_def  = hold_f ? 12'hFFF : 12'($urandom);
            pd_med  = hold_f ? 12'hFFF : 12'($urandom);
            pd_tiny = hold_f ? 12'hFFF : 12'($urandom);
            pp_def  = pd_def;
            pp_med  = pd_med;
            pp_tiny = pd_tiny;
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        ncmp  = 0;
        nfail = 0;
        n     = 0;
        c_def  = '{640, 16, 96, 48, 480, 10, 2, 33, 1, 1'b0, 1'b0};
        c_med  = '{40, 4, 6, 5, 20, 2, 3, 4, 3, 1'b1, 1'b1};
        c_tiny = '{8, 1, 1, 1, 4, 1, 1, 1, 0, 1'b0, 1'b0};
        pd_def = '0; pd_med = '0; pd_tiny = '0;
        pp_def = '0; pp_med = '0; pp_tiny = '0;
        rst = 1'b1;

        // Reset state, with random pixels that must not leak through.
        repeat (3) begin
            @(negedge clk);
            pd_def = 12'($urandom); pd_med = 12'($urandom); pd_tiny = 12'($urandom);
            #1 check_all(0);
        end

        // Release and run several lines of 480p plus two medium frames.
        @(negedge clk);
        rst = 1'b0;
        n   = 0;
        run(3400, 1'b0);

        // Mid-line reset: values must snap back in the same cycle.
        rst = 1'b1;
        #1 check_all(0);
        @(negedge clk);
        #1 check_all(0);
        @(negedge clk);
        rst = 1'b0;
        n   = 0;

        // Saturated pixels first, then random, long enough for the tiny frame counter to wrap.
        run(2000, 1'b1);
        run(17800, 1'b0);
        #1;
        check("tiny.fcnt_wrapped", 64'(tiny_fc), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
